// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared opcodes, flag indices, FSM encoding and enable mapping for the fpu issue path
package fpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_SQRT = 3'd3;
    localparam logic [2:0] OP_CMP  = 3'd4;

    localparam int FLAG_GREAT    = 0;
    localparam int FLAG_EQ       = 1;
    localparam int FLAG_LESS     = 2;
    localparam int FLAG_DIV_ZERO = 3;
    localparam int FLAG_INEXACT  = 4;
    localparam int FLAG_INV      = 5;
    localparam int FLAG_UN       = 6;
    localparam int FLAG_OV       = 7;
    localparam int FLAG_TIMEOUT  = 8;

    localparam logic [31:0] QNAN          = 32'h7FC0_0000;
    localparam logic [8:0]  FLAGS_ILLEGAL = 9'(1 << FLAG_INV);
    localparam logic [8:0]  FLAGS_TIMEOUT = 9'((1 << FLAG_INV) | (1 << FLAG_TIMEOUT));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // One-hot unit select in {comp,div,sqr,mul,add} order; illegal ops select nothing.
    function automatic logic [4:0] op_to_en(input logic [2:0] op);
        case (op)
            OP_ADD:  return 5'b00001;
            OP_MUL:  return 5'b00010;
            OP_SQRT: return 5'b00100;
            OP_DIV:  return 5'b01000;
            OP_CMP:  return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_CMP;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// rtl/fpu_issue_ctrl_if.sv - command and response handshake bundle of the fpu issue controller
interface fpu_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [2:0]       cmd_rm;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [8:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rm, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rm, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
    );
endinterface

// File: rtl/fpu_cmd_fifo.sv
// rtl/fpu_cmd_fifo.sv - command FIFO with registered occupancy count and full/empty flags
module fpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - queues fpu commands, issues them one at a time and returns results in order
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int TAG_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    fpu_issue_ctrl_if.slave         io,
    output logic [31:0]             fpu_in1,
    output logic [31:0]             fpu_in2,
    output logic [2:0]              fpu_opcode,
    output logic [2:0]              fpu_round,
    output logic                    fpu_rst,
    output logic                    fpu_act,
    output logic [4:0]              fpu_en,
    input  logic [31:0]             fpu_out,
    input  logic [7:0]              fpu_flags,
    input  logic                    fpu_done
);
    localparam int EW = 3 + 32 + 32 + 3 + TAG_W;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t           state;
    logic             iss_vld;
    logic [2:0]       iss_op;
    logic [31:0]      iss_a;
    logic [31:0]      iss_b;
    logic [2:0]       iss_rm;
    logic [TAG_W-1:0] iss_tag;
    logic [CW-1:0]    cnt;
    logic [4:0]       en_q;
    logic             act_q;
    logic [31:0]      res_q;
    logic [8:0]       flags_q;
    logic [TAG_W-1:0] tag_q;

    logic [EW-1:0]    fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    assign io.cmd_ready = !fifo_full;
    assign fifo_pop     = (state == IDLE) && !iss_vld && !fifo_empty;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (io.cmd_valid && io.cmd_ready),
        .push_data ({io.cmd_op, io.cmd_a, io.cmd_b, io.cmd_rm, io.cmd_tag}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign fpu_in1    = iss_a;
    assign fpu_in2    = iss_b;
    assign fpu_opcode = iss_op;
    assign fpu_round  = iss_rm;
    assign fpu_rst    = rst || (state == CLEAR);
    assign fpu_act    = act_q;
    assign fpu_en     = en_q;

    assign io.rsp_valid  = (state == HOLD);
    assign io.rsp_result = res_q;
    assign io.rsp_flags  = flags_q;
    assign io.rsp_tag    = tag_q;

    // IDLE spends one cycle loading the issue register and a second decoding it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            iss_vld <= 1'b0;
            iss_op  <= '0;
            iss_a   <= '0;
            iss_b   <= '0;
            iss_rm  <= '0;
            iss_tag <= '0;
            cnt     <= '0;
            en_q    <= '0;
            act_q   <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            tag_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iss_vld) begin
                        iss_vld <= 1'b0;
                        tag_q   <= iss_tag;
                        if (op_legal(iss_op)) begin
                            en_q  <= op_to_en(iss_op);
                            state <= CLEAR;
                        end else begin
                            res_q   <= QNAN;
                            flags_q <= FLAGS_ILLEGAL;
                            state   <= HOLD;
                        end
                    end else if (!fifo_empty) begin
                        iss_vld <= 1'b1;
                        {iss_op, iss_a, iss_b, iss_rm, iss_tag} <= fifo_head;
                    end
                end
                CLEAR: begin
                    cnt   <= '0;
                    act_q <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (fpu_done) begin
                        res_q   <= (iss_op == OP_CMP) ? 32'h0 : fpu_out;
                        flags_q <= {1'b0, fpu_flags};
                        act_q   <= 1'b0;
                        en_q    <= '0;
                        state   <= HOLD;
                    end else if (cnt == CNT_LAST) begin
                        res_q   <= QNAN;
                        flags_q <= FLAGS_TIMEOUT;
                        act_q   <= 1'b0;
                        en_q    <= '0;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (io.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - scoreboard bench for fpu_issue_ctrl with a behavioural fpu responder
module tb_fpu_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_issue_ctrl_if #(.TAG_W(4)) io();

    logic [31:0] fpu_in1, fpu_in2, fpu_out;
    logic [2:0]  fpu_opcode, fpu_round;
    logic        fpu_rst, fpu_act, fpu_done;
    logic [4:0]  fpu_en;
    logic [7:0]  fpu_flags;

    fpu_issue_ctrl #(.DEPTH(4), .TIMEOUT(64), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (io),
        .fpu_in1    (fpu_in1),
        .fpu_in2    (fpu_in2),
        .fpu_opcode (fpu_opcode),
        .fpu_round  (fpu_round),
        .fpu_rst    (fpu_rst),
        .fpu_act    (fpu_act),
        .fpu_en     (fpu_en),
        .fpu_out    (fpu_out),
        .fpu_flags  (fpu_flags),
        .fpu_done   (fpu_done)
    );

    typedef struct {
        logic [31:0] res;
        logic [8:0]  flags;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [31:0] out;
        logic [7:0]  flags;
        int          lat;
        logic [4:0]  en;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  rm;
    } fpu_t;

    exp_t exp_q[$];
    fpu_t fpu_q[$];
    int   run_q[$];
    exp_t mon_e;
    fpu_t cur;

    int n_chk = 0, n_fail = 0, n_rsp = 0;
    int n_clear = 0, n_act = 0, n_en = 0;
    int run_cyc = 0, cur_lat = 0;
    logic prev_act = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [8:0] flags, input logic [3:0] tag);
        exp_t e;
        e.res = res; e.flags = flags; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic push_fpu(input logic [31:0] out, input logic [7:0] flags, input int lat,
                            input logic [4:0] en, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [2:0] rm);
        fpu_t f;
        f.out = out; f.flags = flags; f.lat = lat; f.en = en;
        f.a = a; f.b = b; f.op = op; f.rm = rm;
        fpu_q.push_back(f);
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm, input logic [3:0] tag);
        int g = 0;
        io.cmd_valid = 1'b1; io.cmd_op = op; io.cmd_a = a; io.cmd_b = b;
        io.cmd_rm = rm; io.cmd_tag = tag;
        while (1) begin
            @(negedge clk);
            if (io.cmd_ready) break;
            g++;
            if (g >= 200) begin
                n_chk++; n_fail++;
                $display("FAIL cmd_accept_timeout: cmd_ready 0 for %0d cycles, required 1", g);
                break;
            end
        end
        @(posedge clk);
        #1 io.cmd_valid = 1'b0;
    endtask

    task automatic drain(input int max);
        int g = 0;
        while (exp_q.size() != 0 && g < max) begin
            @(posedge clk);
            g++;
        end
        chk("drain_pending_rsps", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Response monitor: one comparison set per completed handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (fpu_rst) n_clear++;
            if (fpu_act) n_act++;
            if (fpu_en != 5'b0) n_en++;
            if (io.rsp_valid && io.rsp_ready) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_rsp: got tag %0h, required no response", io.rsp_tag);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_result", io.rsp_result, mon_e.res);
                    chk("rsp_flags", io.rsp_flags, mon_e.flags);
                    chk("rsp_tag", io.rsp_tag, mon_e.tag);
                end
            end
        end
    end

    // Behavioural fpu: raises done after the programmed number of RUN cycles (0 = never).
    always @(posedge clk) begin
        #1;
        if (fpu_act) begin
            if (!prev_act) begin
                run_cyc = 0;
                if (fpu_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_issue: fpu_en %b, required no issue", fpu_en);
                    cur_lat = 1; fpu_out = 32'h0; fpu_flags = 8'h0;
                end else begin
                    cur = fpu_q.pop_front();
                    cur_lat = cur.lat; fpu_out = cur.out; fpu_flags = cur.flags;
                    chk("fpu_en", fpu_en, cur.en);
                    chk("fpu_in1", fpu_in1, cur.a);
                    chk("fpu_in2", fpu_in2, cur.b);
                    chk("fpu_opcode", fpu_opcode, cur.op);
                    chk("fpu_round", fpu_round, cur.rm);
                    chk("fpu_rst_in_run", fpu_rst, 0);
                end
            end
            run_cyc++;
            fpu_done = (cur_lat != 0) && (run_cyc == cur_lat);
        end else begin
            if (prev_act) run_q.push_back(run_cyc);
            fpu_done = 1'b0;
        end
        prev_act = fpu_act;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int c0, a0, e0, r0, g;
        io.cmd_valid = 1'b0; io.cmd_op = '0; io.cmd_a = '0; io.cmd_b = '0;
        io.cmd_rm = '0; io.cmd_tag = '0; io.rsp_ready = 1'b0;
        fpu_done = 1'b0; fpu_out = '0; fpu_flags = '0;

        #3;
        chk("rst_cmd_ready", io.cmd_ready, 1);
        chk("rst_fpu_rst", fpu_rst, 1);
        chk("rst_rsp_valid", io.rsp_valid, 0);
        chk("rst_fpu_act", fpu_act, 0);
        chk("rst_fpu_en", fpu_en, 0);
        chk("rst_rsp_result", io.rsp_result, 0);
        chk("rst_rsp_flags", io.rsp_flags, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("released_fpu_rst", fpu_rst, 0);
        io.rsp_ready = 1'b1;

        // add 1.0 + 2.0, done on the third RUN cycle
        c0 = n_clear; run_q.delete();
        push_fpu(32'h40400000, 8'h00, 3, 5'b00001, 32'h3F800000, 32'h40000000, 3'd0, 3'd0);
        push_exp(32'h40400000, 9'h000, 4'd1);
        send(3'd0, 32'h3F800000, 32'h40000000, 3'd0, 4'd1);
        drain(100);
        chk("add_clear_pulses", n_clear - c0, 1);
        chk("add_run_cycles", (run_q.size() > 0) ? run_q[0] : -1, 3);

        // mul with done in the first RUN cycle: accept edge to rsp_valid is 4 edges
        push_fpu(32'h40000000, 8'h00, 1, 5'b00010, 32'h3F800000, 32'h40000000, 3'd1, 3'd2);
        push_exp(32'h40000000, 9'h000, 4'd2);
        send(3'd1, 32'h3F800000, 32'h40000000, 3'd2, 4'd2);
        g = 0;
        while (!io.rsp_valid && g < 20) begin
            @(posedge clk);
            #1 g++;
        end
        chk("accept_to_rsp_latency", g, 4);
        drain(50);

        // five commands with the consumer stalled
        io.rsp_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            push_fpu(32'h41000000 + t, 8'(t), 2, 5'b00001, 32'h3F800000 + t, 32'h40000000, 3'd0, 3'd0);
            push_exp(32'h41000000 + t, {1'b0, 8'(t)}, 4'(t));
        end
        send(3'd0, 32'h3F800000, 32'h40000000, 3'd0, 4'd0);
        g = 0;
        while (!io.rsp_valid && g < 50) begin
            @(posedge clk);
            #1 g++;
        end
        chk("stall_first_rsp_valid", io.rsp_valid, 1);
        for (int t = 1; t < 5; t++) begin
            send(3'd0, 32'h3F800000 + t, 32'h40000000, 3'd0, 4'(t));
        end
        chk("full_cmd_ready", io.cmd_ready, 0);
        @(posedge clk);
        #1 chk("full_cmd_ready_held", io.cmd_ready, 0);
        io.rsp_ready = 1'b1;
        drain(200);

        // illegal opcode never reaches the fpu
        c0 = n_clear; a0 = n_act; e0 = n_en;
        push_exp(32'h7FC00000, 9'h020, 4'd3);
        send(3'd6, 32'h12345678, 32'h9ABCDEF0, 3'd1, 4'd3);
        drain(50);
        chk("illegal_clear_pulses", n_clear - c0, 0);
        chk("illegal_act_cycles", n_act - a0, 0);
        chk("illegal_en_cycles", n_en - e0, 0);

        // div that never completes, followed by a normal add
        run_q.delete();
        push_fpu(32'hDEADBEEF, 8'hFF, 0, 5'b01000, 32'h3F800000, 32'h00000000, 3'd2, 3'd0);
        push_exp(32'h7FC00000, 9'h120, 4'd5);
        push_fpu(32'h40400000, 8'h00, 2, 5'b00001, 32'h40000000, 32'h3F800000, 3'd0, 3'd0);
        push_exp(32'h40400000, 9'h000, 4'd6);
        send(3'd2, 32'h3F800000, 32'h00000000, 3'd0, 4'd5);
        send(3'd0, 32'h40000000, 32'h3F800000, 3'd0, 4'd6);
        drain(300);
        chk("timeout_run_cycles", (run_q.size() > 0) ? run_q[0] : -1, 64);
        chk("after_timeout_run_cycles", (run_q.size() > 1) ? run_q[1] : -1, 2);

        // compare 1.0 vs 2.0: result forced to zero, flags passed through
        push_fpu(32'h12345678, 8'b00000100, 2, 5'b10000, 32'h3F800000, 32'h40000000, 3'd4, 3'd0);
        push_exp(32'h00000000, 9'h004, 4'd7);
        send(3'd4, 32'h3F800000, 32'h40000000, 3'd0, 4'd7);
        drain(50);

        // reset while a div is running with two more queued
        for (int t = 0; t < 3; t++) begin
            push_fpu(32'h0, 8'h0, 0, 5'b01000, 32'h3F800000, 32'h40000000, 3'd2, 3'd0);
            push_exp(32'h7FC00000, 9'h120, 4'(8 + t));
        end
        for (int t = 0; t < 3; t++) begin
            send(3'd2, 32'h3F800000, 32'h40000000, 3'd0, 4'(8 + t));
        end
        g = 0;
        while (!fpu_act && g < 20) begin
            @(posedge clk);
            #1 g++;
        end
        chk("pre_rst_fpu_act", fpu_act, 1);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_fpu_rst", fpu_rst, 1);
        chk("midrst_fpu_act", fpu_act, 0);
        chk("midrst_fpu_en", fpu_en, 0);
        chk("midrst_rsp_valid", io.rsp_valid, 0);
        chk("midrst_rsp_tag", io.rsp_tag, 0);
        chk("midrst_cmd_ready", io.cmd_ready, 1);
        exp_q.delete(); fpu_q.delete();
        r0 = n_rsp; a0 = n_act;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("post_rst_responses", n_rsp - r0, 0);
        chk("post_rst_act_cycles", n_act - a0, 0);
        chk("post_rst_cmd_ready", io.cmd_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
